// File: rtl/dec_to_bin_serial.sv
// Serial packed-BCD to binary converter.
// Consumes one BCD digit per clock, most significant digit first, using
// acc = acc*10 + digit with the multiply built from two shifts and an add.
// A conversion is accepted in IDLE, runs DIGITS cycles in CONV, and then
// spends one cycle in DONE where done_o pulses.
//
// Handshake: start_i is sampled only while busy_o is low. A high start_i on
// an IDLE edge captures bcd_i. Requests made while busy_o is high, including
// the DONE cycle, are dropped rather than queued. bin_o/err_o become valid
// in the cycle where done_o is high and hold until the next done_o pulse.
module dec_to_bin_serial #(
   parameter int DIGITS = 3,
   parameter int OUT_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [4*DIGITS-1:0]   bcd_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [OUT_W-1:0]      bin_o,
   output logic                  err_o,
   output logic [1:0]            state_o
);

   localparam int SR_W  = 4 * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CONV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]        state;
   logic [SR_W-1:0]   sr;
   logic [OUT_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              err_flag;

   logic [3:0]        digit;
   logic              digit_bad;
   logic [OUT_W-1:0]  acc_times10;
   logic [OUT_W-1:0]  acc_next;
   logic              err_next;
   logic              last_digit;

   // Digit datapath: next accumulator and error flag for the digit at the top of sr.
   always_comb begin
      digit       = sr[SR_W-1 -: 4];
      digit_bad   = (digit > 4'd9);
      acc_times10 = (acc << 3) + (acc << 1);
      acc_next    = acc_times10 + OUT_W'(digit);
      err_next    = err_flag | digit_bad;
      last_digit  = (cnt == '0);
   end

   // Control FSM and datapath registers; reset wins over every transition.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         sr       <= '0;
         acc      <= '0;
         cnt      <= '0;
         err_flag <= 1'b0;
         bin_o    <= '0;
         err_o    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  sr       <= bcd_i;
                  acc      <= '0;
                  err_flag <= 1'b0;
                  cnt      <= CNT_W'(DIGITS - 1);
                  state    <= ST_CONV;
               end
            end
            ST_CONV: begin
               sr       <= sr << 4;
               acc      <= acc_next;
               err_flag <= err_next;
               if (last_digit) begin
                  // An invalid digit anywhere forces a zero result.
                  bin_o <= err_next ? '0 : acc_next;
                  err_o <= err_next;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Status outputs decoded straight from the state register.
   always_comb begin
      busy_o  = (state == ST_CONV) || (state == ST_DONE);
      done_o  = (state == ST_DONE);
      state_o = state;
   end

endmodule

// File: tb/tb_dec_to_bin_serial.sv
// Self-checking bench for dec_to_bin_serial (DIGITS=3, OUT_W=10).
module tb_dec_to_bin_serial;

   localparam int DIGITS = 3;
   localparam int OUT_W  = 10;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start_i = 1'b0;
   logic [4*DIGITS-1:0] bcd_i = '0;
   logic                busy_o;
   logic                done_o;
   logic [OUT_W-1:0]    bin_o;
   logic                err_o;
   logic [1:0]          state_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [OUT_W-1:0] last_bin = '0;
   logic             last_err = 1'b0;

   dec_to_bin_serial #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start_i (start_i),
      .bcd_i   (bcd_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .bin_o   (bin_o),
      .err_o   (err_o),
      .state_o (state_o)
   );

   // Clock generation.
   always #5 clk = ~clk;

   // One comparison: count it, and on a miss count and report it.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: decimal value of the digits, zero result if any nibble is not a decimal digit.
   function automatic logic [OUT_W:0] ref_conv(input logic [4*DIGITS-1:0] v);
      int  val;
      bit  bad;
      logic [3:0] d;
      val = 0;
      bad = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         d = v[4*i +: 4];
         if (d > 4'd9) bad = 1'b1;
         val = val * 10 + int'(d);
      end
      val = val % (1 << OUT_W);
      if (bad) return {1'b1, {OUT_W{1'b0}}};
      return {1'b0, val[OUT_W-1:0]};
   endfunction

   // Present a request in an idle cycle; returns #1 after the accepting edge.
   task automatic start_conv(input logic [4*DIGITS-1:0] v);
      start_i = 1'b1;
      bcd_i   = v;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      bcd_i   = 12'($urandom);
   endtask

   // Follow one accepted conversion to its done pulse and the idle cycle after it.
   task automatic wait_done(input string tag, input logic [4*DIGITS-1:0] v);
      logic [OUT_W:0] exp;
      int k;
      int busy_cycles;
      exp = ref_conv(v);
      k = 0;
      busy_cycles = 0;
      do begin
         @(negedge clk);
         k++;
         if (busy_o) busy_cycles++;
      end while (!done_o && k < 12);
      check({tag, "_latency"}, 32'(k), 32'(DIGITS + 1));
      check({tag, "_busy"}, 32'(busy_cycles), 32'(k));
      check({tag, "_bin"}, 32'(bin_o), 32'(exp[OUT_W-1:0]));
      check({tag, "_err"}, 32'(err_o), 32'(exp[OUT_W]));
      last_bin = exp[OUT_W-1:0];
      last_err = exp[OUT_W];
      @(negedge clk);
      check({tag, "_pulse_w"}, 32'(done_o), 32'd0);
      check({tag, "_idle"}, 32'(busy_o), 32'd0);
      check({tag, "_hold"}, 32'(bin_o), 32'(last_bin));
   endtask

   // Directed and random sequence.
   initial begin
      logic [11:0] v;
      int done_seen;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_bin", 32'(bin_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Maximum valid input
      start_conv(12'h999);
      wait_done("max999", 12'h999);
      check("max999_val", 32'(bin_o), 32'h3E7);

      // Idle with no request holds outputs
      repeat (3) @(negedge clk);
      check("idle_hold_bin", 32'(bin_o), 32'd999);
      check("idle_hold_busy", 32'(busy_o), 32'd0);

      start_conv(12'h255);
      wait_done("v255", 12'h255);
      check("v255_val", 32'(bin_o), 32'h0FF);
      start_conv(12'h000);
      wait_done("v000", 12'h000);

      // Invalid tens nibble
      start_conv(12'h0A5);
      wait_done("v0A5", 12'h0A5);
      check("v0A5_errflag", 32'(err_o), 32'd1);

      // Requests while busy are dropped; the held request is taken afterwards
      start_conv(12'h123);
      start_i = 1'b1;
      bcd_i   = 12'h456;
      wait_done("v123", 12'h123);
      @(posedge clk);
      #1;
      start_i = 1'b0;
      wait_done("v456", 12'h456);

      // Reset one edge after acceptance aborts without a pulse
      start_conv(12'h777);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      done_seen = 0;
      @(negedge clk);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_bin", 32'(bin_o), 32'd0);
      check("abort_err", 32'(err_o), 32'd0);
      repeat (5) begin
         @(negedge clk);
         if (done_o) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      start_conv(12'h777);
      wait_done("v777", 12'h777);

      // Random valid BCD, back-to-back
      for (int n = 0; n < 25; n++) begin
         v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         start_conv(v);
         wait_done("rnd_valid", v);
      end

      // Random arbitrary nibbles, error path included
      for (int n = 0; n < 15; n++) begin
         v = 12'($urandom);
         start_conv(v);
         wait_done("rnd_any", v);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
